// File: rtl/select_sequencer_pkg.sv
// Shared encodings for the select sequencer: operand type tags, trap codes and FSM states.
package select_sequencer_pkg;

  localparam int TRAP_W = 4;

  localparam logic [1:0] TYPE_I32 = 2'd0;
  localparam logic [1:0] TYPE_I64 = 2'd1;
  localparam logic [1:0] TYPE_F32 = 2'd2;
  localparam logic [1:0] TYPE_F64 = 2'd3;

  localparam logic [TRAP_W-1:0] TRAP_NONE           = 4'd0;
  localparam logic [TRAP_W-1:0] TRAP_STACK_EMPTY    = 4'd1;
  localparam logic [TRAP_W-1:0] TRAP_TYPES_MISMATCH = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP_C,
    ST_POP_2,
    ST_POP_1,
    ST_CHECK,
    ST_PUSH,
    ST_DONE,
    ST_TRAP
  } state_t;

endpackage

// File: rtl/select_sequencer.sv
// WebAssembly `select` executor: pops cond/val2/val1, type-checks, pushes the chosen value or traps.
// Define SELECT_TYPED_EN to add the `select t` ports (typed, expected_type).
module select_sequencer
  import select_sequencer_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TYPE_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef SELECT_TYPED_EN
  input  logic              typed,
  input  logic [TYPE_W-1:0] expected_type,
`endif
  output logic              busy,
  output logic              done,
  output logic [TRAP_W-1:0] trap,
  output logic              pop_req,
  input  logic              pop_ack,
  input  logic [DATA_W-1:0] pop_data,
  input  logic [TYPE_W-1:0] pop_type,
  input  logic              stack_empty,
  output logic              push_req,
  input  logic              push_ack,
  output logic [DATA_W-1:0] push_data,
  output logic [TYPE_W-1:0] push_type
);

  state_t              state_reg, state_next;
  logic [TRAP_W-1:0]   trap_reg, trap_next;
  logic [31:0]         cond_low_reg;
  logic [TYPE_W-1:0]   cond_type_reg;
  logic [DATA_W-1:0]   v2_data_reg, v1_data_reg;
  logic [TYPE_W-1:0]   v2_type_reg, v1_type_reg;
  logic [DATA_W-1:0]   push_data_reg;
  logic [TYPE_W-1:0]   push_type_reg;
  logic                start_accept;
  logic                typed_fault;
  logic                type_fault;

  assign start_accept = (state_reg == ST_IDLE) && start && (trap_reg == TRAP_NONE);

`ifdef SELECT_TYPED_EN
  logic              typed_reg;
  logic [TYPE_W-1:0] expected_type_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      typed_reg         <= 1'b0;
      expected_type_reg <= '0;
    end else if (start_accept) begin
      typed_reg         <= typed;
      expected_type_reg <= expected_type;
    end
  end

  assign typed_fault = typed_reg && (v1_type_reg != expected_type_reg);
`else
  assign typed_fault = 1'b0;
`endif

  // Only the low word of the condition participates, matching i32 semantics.
  assign type_fault = (cond_type_reg != TYPE_W'(TYPE_I32)) ||
                      (v1_type_reg != v2_type_reg) || typed_fault;

  always_comb begin
    state_next = state_reg;
    trap_next  = trap_reg;
    case (state_reg)
      ST_IDLE:  if (start_accept) state_next = ST_POP_C;
      ST_POP_C, ST_POP_2, ST_POP_1: begin
        if (pop_ack) begin
          state_next = (state_reg == ST_POP_C) ? ST_POP_2 :
                       (state_reg == ST_POP_2) ? ST_POP_1 : ST_CHECK;
        end else if (stack_empty) begin
          state_next = ST_TRAP;
          trap_next  = TRAP_STACK_EMPTY;
        end
      end
      ST_CHECK: begin
        if (type_fault) begin
          state_next = ST_TRAP;
          trap_next  = TRAP_TYPES_MISMATCH;
        end else begin
          state_next = ST_PUSH;
        end
      end
      ST_PUSH:  if (push_ack) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      ST_TRAP:  state_next = ST_TRAP;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      trap_reg      <= TRAP_NONE;
      cond_low_reg  <= '0;
      cond_type_reg <= '0;
      v2_data_reg   <= '0;
      v2_type_reg   <= '0;
      v1_data_reg   <= '0;
      v1_type_reg   <= '0;
      push_data_reg <= '0;
      push_type_reg <= '0;
    end else begin
      state_reg <= state_next;
      trap_reg  <= trap_next;
      if (pop_ack) begin
        case (state_reg)
          ST_POP_C: begin
            cond_low_reg  <= pop_data[31:0];
            cond_type_reg <= pop_type;
          end
          ST_POP_2: begin
            v2_data_reg <= pop_data;
            v2_type_reg <= pop_type;
          end
          ST_POP_1: begin
            v1_data_reg <= pop_data;
            v1_type_reg <= pop_type;
          end
          default: ;
        endcase
      end
      if ((state_reg == ST_CHECK) && !type_fault) begin
        push_data_reg <= (cond_low_reg != 32'd0) ? v1_data_reg : v2_data_reg;
        push_type_reg <= v1_type_reg;
      end
    end
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    pop_req  = 1'b0;
    push_req = 1'b0;
    case (state_reg)
      ST_POP_C, ST_POP_2, ST_POP_1: begin
        busy    = 1'b1;
        pop_req = 1'b1;
      end
      ST_CHECK: busy = 1'b1;
      ST_PUSH: begin
        busy     = 1'b1;
        push_req = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign trap      = trap_reg;
  assign push_data = push_data_reg;
  assign push_type = push_type_reg;

endmodule

// File: tb/tb_select_sequencer.sv
// Randomized bench for select_sequencer: an operand-stack queue answers pop/push requests and
// a rule-level model predicts result, trap code and cycle latency for every select.
module tb_select_sequencer;
  import select_sequencer_pkg::*;

  localparam int DW = 64;
  localparam int TW = 2;
`ifdef SELECT_TYPED_EN
  localparam bit TYPED_ON = 1'b1;
`else
  localparam bit TYPED_ON = 1'b0;
`endif

  typedef struct packed {
    logic [TW-1:0] t;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          typed;
  logic [TW-1:0] expected_type;
  logic          busy, done;
  logic [3:0]    trap;
  logic          pop_req, pop_ack;
  logic [DW-1:0] pop_data;
  logic [TW-1:0] pop_type;
  logic          stack_empty;
  logic          push_req, push_ack;
  logic [DW-1:0] push_data;
  logic [TW-1:0] push_type;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t stk[$];

  always #5 clk = ~clk;

  select_sequencer #(.DATA_W(DW), .TYPE_W(TW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
`ifdef SELECT_TYPED_EN
    .typed(typed),
    .expected_type(expected_type),
`endif
    .busy(busy),
    .done(done),
    .trap(trap),
    .pop_req(pop_req),
    .pop_ack(pop_ack),
    .pop_data(pop_data),
    .pop_type(pop_type),
    .stack_empty(stack_empty),
    .push_req(push_req),
    .push_ack(push_ack),
    .push_data(push_data),
    .push_type(push_type)
  );

  function automatic ent_t mk(input logic [TW-1:0] t, input logic [DW-1:0] d);
    ent_t e;
    e.t = t;
    e.d = d;
    return e;
  endfunction

  // v1 deepest, cond on top
  task automatic load3(input ent_t v1, input ent_t v2, input ent_t c);
    stk.delete();
    stk.push_back(v1);
    stk.push_back(v2);
    stk.push_back(c);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; pop_ack = 1'b0; push_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stk.delete();
    stack_empty = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle. Predicts the outcome from the stack contents,
  // then acts as the stack for up to 200 cycles.
  task automatic run_select(input string name, input int dp, input int dpu, input logic typ,
                            input logic [TW-1:0] et, input bit b2b, input bit abort);
    logic [3:0] etrap;
    ent_t eres, a, b, c;
    int   n, elat, cyc, pc, qc, pushes;
    bit   fin, saw_push;
    n = stk.size();
    etrap = TRAP_NONE;
    eres = '0;
    if (n < 3) begin
      etrap = TRAP_STACK_EMPTY;
      elat = 2 + n * (dp + 1);
    end else begin
      c = stk[n-1]; b = stk[n-2]; a = stk[n-3];
      elat = 5 + 3 * dp;
      if (c.t != TYPE_I32 || a.t != b.t || (TYPED_ON && typ && a.t != et)) begin
        etrap = TRAP_TYPES_MISMATCH;
      end else begin
        eres.t = a.t;
        eres.d = (c.d[31:0] != 32'd0) ? a.d : b.d;
        elat = 6 + 3 * dp + dpu;
      end
    end

    start = 1'b1; typed = typ; expected_type = et;
    stack_empty = (stk.size() == 0);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; pc = 0; qc = 0; pushes = 0; fin = 1'b0; saw_push = 1'b0;
    while (!fin && cyc < 200) begin
      n_cmp++;
      if (pop_req && push_req) begin
        n_err++;
        $display("FAIL %s req_exclusive: pop_req=%0b push_req=%0b, required not both", name, pop_req, push_req);
      end
      if (push_req) saw_push = 1'b1;
      if (done || trap != 0) begin
        fin = 1'b1;
      end else begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy_active: busy=%0b at cycle %0d, required 1", name, busy, cyc);
        end
        if (abort && push_req) begin
          reset = 1'b0;
          #1;
          n_cmp++;
          if ({busy, done, trap, pop_req, push_req} !== '0 || push_data !== '0 || push_type !== '0) begin
            n_err++;
            $display("FAIL %s abort_outputs: busy=%0b done=%0b trap=%0d pop=%0b push=%0b data=%h type=%0d, required all 0",
                     name, busy, done, trap, pop_req, push_req, push_data, push_type);
          end
          $display("txn %s: reset asserted during push at cycle %0d", name, cyc);
          return;
        end
        pop_ack = 1'b0; push_ack = 1'b0;
        stack_empty = (stk.size() == 0);
        if (pop_req) begin
          if (pc == dp && stk.size() > 0) begin
            ent_t e;
            e = stk.pop_back();
            pop_ack = 1'b1; pop_data = e.d; pop_type = e.t; pc = 0;
          end else begin
            pop_ack = 1'b0; pop_data = {$urandom, $urandom}; pc++;
          end
        end
        if (push_req) begin
          n_cmp++;
          if (push_data !== eres.d || push_type !== eres.t) begin
            n_err++;
            $display("FAIL %s push_value: data=%h type=%0d, required data=%h type=%0d",
                     name, push_data, push_type, eres.d, eres.t);
          end
          if (qc == dpu) begin
            push_ack = 1'b1; stk.push_back(mk(push_type, push_data)); pushes++; qc = 0;
          end else begin
            qc++;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    pop_ack = 1'b0; push_ack = 1'b0;
    stack_empty = (stk.size() == 0);

    n_cmp++;
    if (!fin) begin
      n_err++;
      $display("FAIL %s timeout: no done/trap after %0d cycles, required within %0d", name, cyc, elat);
    end
    n_cmp++;
    if (trap !== etrap) begin
      n_err++;
      $display("FAIL %s trap_code: trap=%0d, required %0d", name, trap, etrap);
    end
    n_cmp++;
    if (cyc != elat) begin
      n_err++;
      $display("FAIL %s latency: finished at start+%0d, required start+%0d", name, cyc, elat);
    end
    n_cmp++;
    if (pushes != ((etrap == TRAP_NONE) ? 1 : 0) || (etrap != TRAP_NONE && saw_push)) begin
      n_err++;
      $display("FAIL %s push_count: pushes=%0d saw_push_req=%0b, required %0d", name, pushes, saw_push,
               (etrap == TRAP_NONE) ? 1 : 0);
    end
    $display("txn %s: trap=%0d data=%h type=%0d cycles=%0d", name, trap, eres.d, eres.t, cyc);

    if (etrap == TRAP_NONE) begin
      if (b2b) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || pop_req !== 1'b0) begin
        n_err++;
        $display("FAIL %s after_done: done=%0b busy=%0b pop_req=%0b, required 0/0/0", name, done, busy, pop_req);
      end
    end else begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (trap !== etrap || busy !== 1'b0 || pop_req !== 1'b0 || push_req !== 1'b0) begin
        n_err++;
        $display("FAIL %s trap_sticky: trap=%0d busy=%0b pop=%0b push=%0b, required trap=%0d and 0/0/0",
                 name, trap, busy, pop_req, push_req, etrap);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; typed = 1'b0; expected_type = '0;
    pop_ack = 1'b0; pop_data = '0; pop_type = '0; stack_empty = 1'b1; push_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, trap, pop_req, push_req} !== '0 || push_data !== '0 || push_type !== '0) begin
      n_err++;
      $display("FAIL reset_values: busy=%0b done=%0b trap=%0d pop=%0b push=%0b data=%h type=%0d, required all 0",
               busy, done, trap, pop_req, push_req, push_data, push_type);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load3(mk(TYPE_I64, 64'h11), mk(TYPE_I64, 64'h22), mk(TYPE_I32, 64'h1));
    run_select("basic_true", 0, 0, 1'b0, TYPE_I32, 1'b0, 1'b0);
    load3(mk(TYPE_I64, 64'h11), mk(TYPE_I64, 64'h22), mk(TYPE_I32, 64'h1_0000_0000));
    run_select("cond_low_word", 0, 0, 1'b0, TYPE_I32, 1'b0, 1'b0);
  endtask

  task automatic test_type_traps();
    load3(mk(TYPE_I64, 64'h11), mk(TYPE_I64, 64'h22), mk(TYPE_I64, 64'h1));
    run_select("cond_i64", 0, 0, 1'b0, TYPE_I32, 1'b0, 1'b0);
    do_reset();
    load3(mk(TYPE_I32, 64'h5), mk(TYPE_F32, 64'h5), mk(TYPE_I32, 64'h1));
    run_select("v1v2_mismatch", 0, 0, 1'b0, TYPE_I32, 1'b0, 1'b0);
    do_reset();
  endtask

  task automatic test_stack_and_delays();
    stk.delete();
    stk.push_back(mk(TYPE_I64, 64'h22));
    stk.push_back(mk(TYPE_I32, 64'h1));
    run_select("stack_empty", 3, 0, 1'b0, TYPE_I32, 1'b0, 1'b0);
    do_reset();
    load3(mk(TYPE_F64, 64'hAAAA), mk(TYPE_F64, 64'hBBBB), mk(TYPE_I32, 64'h0));
    run_select("delayed_acks", 3, 2, 1'b0, TYPE_I32, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    load3(mk(TYPE_I32, 64'h7), mk(TYPE_I32, 64'h8), mk(TYPE_I32, 64'h3));
    run_select("start_in_done", 0, 0, 1'b0, TYPE_I32, 1'b1, 1'b0);
    load3(mk(TYPE_F32, 64'h9), mk(TYPE_F32, 64'hA), mk(TYPE_I32, 64'h0));
    run_select("start_after_done", 0, 0, 1'b0, TYPE_I32, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_push();
    load3(mk(TYPE_I64, 64'h33), mk(TYPE_I64, 64'h44), mk(TYPE_I32, 64'h1));
    run_select("abort_push", 0, 1000, 1'b0, TYPE_I32, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, trap, pop_req, push_req} !== '0) begin
      n_err++;
      $display("FAIL abort_hold: busy=%0b done=%0b trap=%0d pop=%0b push=%0b, required all 0",
               busy, done, trap, pop_req, push_req);
    end
    reset = 1'b1; pop_ack = 1'b0; push_ack = 1'b0;
    @(negedge clk);
    load3(mk(TYPE_I64, 64'h55), mk(TYPE_I64, 64'h66), mk(TYPE_I32, 64'h0));
    run_select("after_abort", 0, 0, 1'b0, TYPE_I32, 1'b0, 1'b0);
  endtask

  task automatic test_typed();
    load3(mk(TYPE_I64, 64'h1), mk(TYPE_I64, 64'h2), mk(TYPE_I32, 64'h1));
    run_select("typed_mismatch", 0, 0, 1'b1, TYPE_F64, 1'b0, 1'b0);
    if (trap != 0) do_reset();
    load3(mk(TYPE_I64, 64'h1), mk(TYPE_I64, 64'h2), mk(TYPE_I32, 64'h1));
    run_select("typed_match", 0, 0, 1'b1, TYPE_I64, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [TW-1:0] t1, t2, tc;
      logic [DW-1:0] cd;
      t1 = TW'($urandom_range(0, 3));
      t2 = ($urandom_range(0, 4) == 0) ? TW'($urandom_range(0, 3)) : t1;
      tc = ($urandom_range(0, 5) == 0) ? TW'($urandom_range(0, 3)) : TYPE_I32;
      cd = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) cd[31:0] = 32'd0;
      load3(mk(t1, {$urandom, $urandom}), mk(t2, {$urandom, $urandom}), mk(tc, cd));
      if ($urandom_range(0, 9) == 0) void'(stk.pop_front());
      run_select($sformatf("rand%0d", i), $urandom_range(0, 2), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), TW'($urandom_range(0, 3)), 1'b0, 1'b0);
      if (trap != 0) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_type_traps();
    test_stack_and_delays();
    test_back_to_back();
    test_reset_mid_push();
    test_typed();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "global timeout");
  end

endmodule
